// File: rtl/compare_cards_pkg.sv
// Shared constants, FSM state type and board ROM function for the compare_cards pair-matching core.
package compare_cards_pkg;

  localparam int unsigned NUM_CARDS = 36;
  localparam int unsigned NUM_PAIRS = 18;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned VAL_W     = 5;
  localparam int unsigned CNT_W     = 5;

  localparam logic [2:0] PLAY_STATE = 3'd2;

  typedef enum logic [1:0] {
    ST_FIRST   = 2'd0,
    ST_SECOND  = 2'd1,
    ST_COMPARE = 2'd2
  } state_t;

  // Positions i and i+18 hold the same value; position 0 maps to 15.
  function automatic logic [VAL_W-1:0] rom_value(input logic [IDX_W-1:0] idx);
    int unsigned v;
    v = ((int'(idx) % NUM_PAIRS) + 15) % NUM_PAIRS;
    return v[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/compare_cards_card_rom.sv
// Combinational 36-entry board ROM: position index to card value.
module card_rom
  import compare_cards_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [VAL_W-1:0] o_val
);

  always_comb begin
    o_val = '0;
    if (i_idx < IDX_W'(NUM_CARDS)) o_val = rom_value(i_idx);
  end

endmodule

// File: rtl/compare_cards.sv
// Pair-matching core of the 6x6 memory game: latches two selections, compares, counts pairs, flags GO.
// Optional attempts counter output enabled by defining COMPARE_CARDS_ATTEMPTS_EN.
module compare_cards
  import compare_cards_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             A,
  input  logic [2:0]       inputState,
  input  logic [IDX_W-1:0] mem6x6,
  output logic [VAL_W-1:0] data1,
  output logic [VAL_W-1:0] data2,
  output logic             cardOneTwo,
  output logic [CNT_W-1:0] pairsFound,
`ifdef COMPARE_CARDS_ATTEMPTS_EN
  output logic             GO,
  output logic [7:0]       attempts
`else
  output logic             GO
`endif
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_a_q;
  logic [IDX_W-1:0]       r_cardmem1;
  logic [IDX_W-1:0]       r_cardmem2;
  logic [NUM_CARDS-1:0]   r_matched;
  logic [VAL_W-1:0]       r_data1;
  logic [VAL_W-1:0]       r_data2;
  logic                   r_card_one_two;
  logic [CNT_W-1:0]       r_pairs;
  logic                   r_go;

  logic                   w_press;
  logic                   w_in_play;
  logic                   w_idx_ok;
  logic                   w_unmatched;
  logic                   w_valid_first;
  logic                   w_valid_second;
  logic                   w_is_match;
  logic [VAL_W-1:0]       w_rom_val;

  card_rom u_card_rom (
    .i_idx (mem6x6),
    .o_val (w_rom_val)
  );

  assign w_press        = A & ~r_a_q;
  assign w_in_play      = (inputState == PLAY_STATE);
  assign w_idx_ok       = (mem6x6 < IDX_W'(NUM_CARDS));
  // Out-of-range indices are masked by w_idx_ok before the matched bit matters.
  assign w_unmatched    = w_idx_ok && !r_matched[mem6x6];
  assign w_valid_first  = w_press && w_in_play && w_unmatched && !r_go;
  assign w_valid_second = w_valid_first && (mem6x6 != r_cardmem1);
  assign w_is_match     = (r_data1 == r_data2) && (r_pairs < CNT_W'(NUM_PAIRS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FIRST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FIRST: begin
        if (w_valid_first) w_next = ST_SECOND;
      end
      ST_SECOND: begin
        if (!w_in_play)          w_next = ST_FIRST;
        else if (w_valid_second) w_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        w_next = ST_FIRST;
      end
      default: begin
        w_next = ST_FIRST;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_q          <= 1'b0;
      r_cardmem1     <= '0;
      r_cardmem2     <= '0;
      r_matched      <= '0;
      r_data1        <= '0;
      r_data2        <= '0;
      r_card_one_two <= 1'b0;
      r_pairs        <= '0;
      r_go           <= 1'b0;
    end else begin
      r_a_q <= A;
      case (r_state)
        ST_FIRST: begin
          if (w_valid_first) begin
            r_cardmem1     <= mem6x6;
            r_data1        <= w_rom_val;
            r_card_one_two <= 1'b1;
          end
        end
        ST_SECOND: begin
          if (!w_in_play) begin
            r_card_one_two <= 1'b0;
          end else if (w_valid_second) begin
            r_cardmem2     <= mem6x6;
            r_data2        <= w_rom_val;
            r_card_one_two <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (w_is_match) begin
            r_pairs                <= r_pairs + 1'b1;
            r_matched[r_cardmem1]  <= 1'b1;
            r_matched[r_cardmem2]  <= 1'b1;
            if (r_pairs == CNT_W'(NUM_PAIRS - 1)) r_go <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef COMPARE_CARDS_ATTEMPTS_EN
  logic [7:0] r_attempts;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_attempts <= '0;
    end else if (r_state == ST_COMPARE && r_attempts != '1) begin
      r_attempts <= r_attempts + 8'd1;
    end
  end

  assign attempts = r_attempts;
`endif

  assign data1      = r_data1;
  assign data2      = r_data2;
  assign cardOneTwo = r_card_one_two;
  assign pairsFound = r_pairs;
  assign GO         = r_go;

endmodule

// File: tb/tb_compare_cards.sv
// Directed self-checking bench for compare_cards with a small reference model for the random phase.
module tb_compare_cards;

  logic       clock;
  logic       reset_n;
  logic       A;
  logic [2:0] inputState;
  logic [5:0] mem6x6;
  logic [4:0] data1;
  logic [4:0] data2;
  logic       cardOneTwo;
  logic [4:0] pairsFound;
  logic       GO;

  int tests;
  int fails;

  compare_cards dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .A          (A),
    .inputState (inputState),
    .mem6x6     (mem6x6),
    .data1      (data1),
    .data2      (data2),
    .cardOneTwo (cardOneTwo),
    .pairsFound (pairsFound),
    .GO         (GO)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int idx);
    @(negedge clock);
    mem6x6 = 6'(idx);
    A = 1'b1;
    @(negedge clock);
    A = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model state for the random phase
  bit m_matched[36];
  int m_state;
  int m_c1;
  int m_pairs;
  int prev_pairs;

  function automatic int rom(input int i);
    return ((i % 18) + 15) % 18;
  endfunction

  function automatic void model_press(input int idx);
    bit ok;
    ok = (idx < 36) && !m_matched[idx] && (m_pairs < 18);
    if (m_state == 0) begin
      if (ok) begin
        m_c1 = idx;
        m_state = 1;
      end
    end else if (ok && idx != m_c1) begin
      if (rom(idx) == rom(m_c1)) begin
        m_matched[idx] = 1'b1;
        m_matched[m_c1] = 1'b1;
        m_pairs++;
      end
      m_state = 0;
    end
  endfunction

  initial begin
    int exp_pairs;
    int a;
    int b;
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    A = 1'b0;
    inputState = 3'd2;
    mem6x6 = '0;
    step(2);
    chk("rst_data1", int'(data1), 0);
    chk("rst_data2", int'(data2), 0);
    chk("rst_c12", int'(cardOneTwo), 0);
    chk("rst_pairs", int'(pairsFound), 0);
    chk("rst_go", int'(GO), 0);
    reset_n = 1'b1;

    // First pair 0/18
    press(0);
    chk("p0_data1", int'(data1), 15);
    chk("p0_c12", int'(cardOneTwo), 1);
    press(18);
    chk("p18_data2", int'(data2), 15);
    chk("p18_c12", int'(cardOneTwo), 0);
    chk("p18_pairs_pre", int'(pairsFound), 0);
    step(1);
    chk("p18_pairs", int'(pairsFound), 1);

    // Same card twice, then its partner
    press(5);
    chk("p5_data1", int'(data1), 2);
    press(5);
    chk("p5again_c12", int'(cardOneTwo), 1);
    chk("p5again_data2", int'(data2), 15);
    press(23);
    chk("p23_data2", int'(data2), 2);
    step(1);
    chk("p23_pairs", int'(pairsFound), 2);

    // Mismatch, then reselect matched cards
    press(1);
    chk("p1_data1", int'(data1), 16);
    press(2);
    chk("p2_data2", int'(data2), 17);
    step(1);
    chk("mis_pairs", int'(pairsFound), 2);
    press(0);
    chk("rematch0_c12", int'(cardOneTwo), 0);
    chk("rematch0_data1", int'(data1), 16);
    press(18);
    chk("rematch18_c12", int'(cardOneTwo), 0);

    // Wrong game state and out-of-range index
    inputState = 3'd0;
    press(3);
    chk("nplay_c12", int'(cardOneTwo), 0);
    chk("nplay_data1", int'(data1), 16);
    inputState = 3'd2;
    press(40);
    chk("oor_c12", int'(cardOneTwo), 0);
    chk("oor_data1", int'(data1), 16);
    press(4);
    chk("p4_data1", int'(data1), 1);
    chk("p4_c12", int'(cardOneTwo), 1);
    inputState = 3'd0;
    step(1);
    chk("abort_c12", int'(cardOneTwo), 0);
    chk("abort_data1", int'(data1), 1);
    inputState = 3'd2;

    // Complete the board
    exp_pairs = 2;
    for (int i = 0; i < 18; i++) begin
      press(i);
      press(i + 18);
      step(1);
      if (i != 0 && i != 5) exp_pairs++;
      chk("all_pairs", int'(pairsFound), exp_pairs);
      chk("all_go", int'(GO), (exp_pairs == 18) ? 1 : 0);
    end
    chk("end_data1", int'(data1), 14);
    chk("end_data2", int'(data2), 14);

    // Presses after game over are ignored
    press(1);
    chk("go_c12", int'(cardOneTwo), 0);
    chk("go_data1", int'(data1), 14);
    press(19);
    step(1);
    chk("go_pairs", int'(pairsFound), 18);
    chk("go_sticky", int'(GO), 1);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("arst_go", int'(GO), 0);
    chk("arst_pairs", int'(pairsFound), 0);
    chk("arst_data1", int'(data1), 0);
    chk("arst_data2", int'(data2), 0);
    step(1);
    reset_n = 1'b1;
    press(7);
    chk("p7_c12", int'(cardOneTwo), 1);
    chk("p7_data1", int'(data1), 4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst2_c12", int'(cardOneTwo), 0);
    chk("arst2_data1", int'(data1), 0);
    step(1);
    reset_n = 1'b1;
    press(25);
    chk("p25_data1", int'(data1), 4);
    press(7);
    step(1);
    chk("post_rst_pairs", int'(pairsFound), 1);

    // Random play against the model
    foreach (m_matched[k]) m_matched[k] = 1'b0;
    m_matched[25] = 1'b1;
    m_matched[7] = 1'b1;
    m_state = 0;
    m_c1 = 7;
    m_pairs = 1;
    prev_pairs = 1;
    for (int n = 0; n < 800; n++) begin
      a = int'($urandom_range(35, 0));
      b = int'($urandom_range(35, 0));
      press(a);
      model_press(a);
      press(b);
      model_press(b);
      step(1);
      chk("rnd_pairs", int'(pairsFound), m_pairs);
      chk("rnd_mono", (int'(pairsFound) >= prev_pairs) ? 1 : 0, 1);
      chk("rnd_go", int'(GO), (m_pairs == 18) ? 1 : 0);
      prev_pairs = int'(pairsFound);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
